// File: rtl/spi_regbank.sv
// System-clock register bank behind the SPI slave: ID/CTRL/STATUS/EVENT/MASK/TIMER/WRCNT/scratch.
// All outputs are registered; rdat has one clk of latency from addr.
module spi_regbank #(
    parameter int              ASZ      = 7,
    parameter int              DSZ      = 32,
    parameter int              NSCR     = 8,
    parameter logic [DSZ-1:0]  ID_VALUE = 32'h5350_0001
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           we,
    input  logic [ASZ-1:0] addr,
    input  logic [DSZ-1:0] wdat,
    output logic [DSZ-1:0] rdat,
    output logic [DSZ-1:0] ctrl,
    output logic           ctrl_wr,
    input  logic [DSZ-1:0] status_in,
    input  logic [DSZ-1:0] event_in,
    output logic           irq
);

    localparam logic [ASZ-1:0] A_ID     = ASZ'(7'h00);
    localparam logic [ASZ-1:0] A_CTRL   = ASZ'(7'h01);
    localparam logic [ASZ-1:0] A_STATUS = ASZ'(7'h02);
    localparam logic [ASZ-1:0] A_EVENT  = ASZ'(7'h03);
    localparam logic [ASZ-1:0] A_MASK   = ASZ'(7'h04);
    localparam logic [ASZ-1:0] A_TIMER  = ASZ'(7'h05);
    localparam logic [ASZ-1:0] A_WRCNT  = ASZ'(7'h06);
    localparam logic [ASZ-1:0] A_SCR    = ASZ'(7'h08);

    function automatic logic [ASZ-1:0] scr_addr(input int idx);
        scr_addr = A_SCR + ASZ'(idx);
    endfunction

    logic [DSZ-1:0] event_r;
    logic [DSZ-1:0] mask_r;
    logic [DSZ-1:0] timer_r;
    logic [DSZ-1:0] wrcnt_r;
    logic [DSZ-1:0] scratch_r [NSCR];
    logic [DSZ-1:0] event_next_s;
    logic [DSZ-1:0] mask_next_s;
    logic [DSZ-1:0] rd_s;

    // Next EVENT/MASK values; irq is registered from these so it tracks them with one clk latency.
    always_comb begin
        event_next_s = event_r;
        mask_next_s  = mask_r;
        if (we && addr == A_EVENT) begin
            event_next_s = event_r & ~wdat;
        end else begin
            event_next_s = event_r;
        end
        // Set wins over a same-cycle write-1-to-clear.
        event_next_s = event_next_s | event_in;
        if (we && addr == A_MASK) begin
            mask_next_s = wdat;
        end else begin
            mask_next_s = mask_r;
        end
    end

    // Combinational read decode; unmapped addresses read zero.
    always_comb begin
        rd_s = '0;
        case (addr)
            A_ID:     rd_s = ID_VALUE;
            A_CTRL:   rd_s = ctrl;
            A_STATUS: rd_s = status_in;
            A_EVENT:  rd_s = event_r;
            A_MASK:   rd_s = mask_r;
            A_TIMER:  rd_s = timer_r;
            A_WRCNT:  rd_s = wrcnt_r;
            default: begin
                for (int i = 0; i < NSCR; i++) begin
                    if (addr == scr_addr(i)) begin
                        rd_s = scratch_r[i];
                    end else begin
                        rd_s = rd_s;
                    end
                end
            end
        endcase
    end

    // Register state, write path, registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdat    <= '0;
            ctrl    <= '0;
            ctrl_wr <= 1'b0;
            irq     <= 1'b0;
            event_r <= '0;
            mask_r  <= '0;
            timer_r <= '0;
            wrcnt_r <= '0;
            for (int i = 0; i < NSCR; i++) begin
                scratch_r[i] <= '0;
            end
        end else begin
            rdat    <= rd_s;
            event_r <= event_next_s;
            mask_r  <= mask_next_s;
            irq     <= |(event_next_s & mask_next_s);
            ctrl_wr <= we && (addr == A_CTRL);
            if (we && addr == A_CTRL) begin
                ctrl <= wdat;
            end
            if (we && addr == A_TIMER) begin
                timer_r <= wdat;
            end else begin
                timer_r <= timer_r + DSZ'(1);
            end
            if (we) begin
                wrcnt_r <= wrcnt_r + DSZ'(1);
            end
            for (int i = 0; i < NSCR; i++) begin
                if (we && addr == scr_addr(i)) begin
                    scratch_r[i] <= wdat;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_regbank.sv
// Directed self-checking bench for spi_regbank.
module tb_spi_regbank;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [6:0]  addr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic [31:0] ctrl;
    logic        ctrl_wr;
    logic [31:0] status_in;
    logic [31:0] event_in;
    logic        irq;

    int total = 0;
    int bad   = 0;

    spi_regbank dut (
        .clk(clk), .reset(reset), .we(we), .addr(addr), .wdat(wdat),
        .rdat(rdat), .ctrl(ctrl), .ctrl_wr(ctrl_wr),
        .status_in(status_in), .event_in(event_in), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        addr = a;
        wdat = d;
        we   = 1'b1;
        tick();
        we   = 1'b0;
    endtask

    initial begin
        reset = 1'b0; we = 1'b0; addr = 7'h00; wdat = 32'h0;
        status_in = 32'hA5A5_0000; event_in = 32'h0;

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ctrl", ctrl, 32'h0);
            chk("rst_irq", {31'h0, irq}, 32'h0);
        end
        chk("rst_rdat", rdat, 32'h0);
        chk("rst_ctrl_wr", {31'h0, ctrl_wr}, 32'h0);

        reset = 1'b1;
        addr  = 7'h00;
        tick();
        chk("id", rdat, 32'h5350_0001);

        wr(7'h01, 32'hDEAD_BEEF);
        chk("ctrl_val", ctrl, 32'hDEAD_BEEF);
        chk("ctrl_wr_hi", {31'h0, ctrl_wr}, 32'h1);
        tick();
        chk("ctrl_wr_lo", {31'h0, ctrl_wr}, 32'h0);
        chk("ctrl_rd", rdat, 32'hDEAD_BEEF);
        addr = 7'h06;
        tick();
        chk("wrcnt1", rdat, 32'h1);

        event_in = 32'h0000_0005;
        tick();
        event_in = 32'h0;
        chk("irq_nomask", {31'h0, irq}, 32'h0);
        addr = 7'h03;
        tick();
        chk("event5", rdat, 32'h5);
        wr(7'h04, 32'h4);
        chk("irq_mask", {31'h0, irq}, 32'h1);
        wr(7'h03, 32'h4);
        chk("irq_clr", {31'h0, irq}, 32'h0);
        tick();
        chk("event1", rdat, 32'h1);

        wr(7'h03, 32'h1);
        tick();
        chk("event0", rdat, 32'h0);
        event_in = 32'h1;
        wr(7'h03, 32'h1);
        event_in = 32'h0;
        tick();
        chk("collide", rdat, 32'h1);

        wr(7'h05, 32'hFFFF_FFFE);
        tick();
        chk("tmr0", rdat, 32'hFFFF_FFFE);
        tick();
        chk("tmr1", rdat, 32'hFFFF_FFFF);
        tick();
        chk("tmr_wrap", rdat, 32'h0);
        tick();
        chk("tmr3", rdat, 32'h1);

        wr(7'h00, 32'hFFFF_FFFF);
        wr(7'h02, 32'hFFFF_FFFF);
        wr(7'h7F, 32'hFFFF_FFFF);
        addr = 7'h00;
        tick();
        chk("id_ro", rdat, 32'h5350_0001);
        addr = 7'h02;
        tick();
        chk("status", rdat, 32'hA5A5_0000);
        addr = 7'h7F;
        tick();
        chk("unmapped", rdat, 32'h0);
        addr = 7'h06;
        tick();
        chk("wrcnt9", rdat, 32'h9);

        wr(7'h0F, 32'h0000_1234);
        tick();
        chk("scr_top", rdat, 32'h0000_1234);
        addr = 7'h10;
        tick();
        chk("scr_over", rdat, 32'h0);
        addr = 7'h07;
        tick();
        chk("gap07", rdat, 32'h0);

        event_in = 32'h4;
        tick();
        event_in = 32'h0;
        chk("irq_pre", {31'h0, irq}, 32'h1);
        addr = 7'h01;
        tick();
        chk("ctrl_pre", rdat, 32'hDEAD_BEEF);
        wdat = 32'h1111_1111;
        we   = 1'b1;
        #3;
        reset = 1'b0;
        #1;
        chk("async_rdat", rdat, 32'h0);
        chk("async_ctrl", ctrl, 32'h0);
        chk("async_irq", {31'h0, irq}, 32'h0);
        chk("async_ctrl_wr", {31'h0, ctrl_wr}, 32'h0);
        tick();
        we    = 1'b0;
        reset = 1'b1;
        tick();
        chk("cancel_wr", rdat, 32'h0);
        addr = 7'h06;
        tick();
        chk("wrcnt_rst", rdat, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
